frac_tcam_wr: RTL and testbench

- Rule-programming engine for the fractured TCAM match table; it is the writer side of the `we`/`rules` load interface that the table consumes.
- Keeps a shadow copy of every entry (key, mask, valid).
- On each install or delete request it rebuilds the affected 8-entry group by driving 32 shift cycles of per-key-value match bits.
- After reset it clears the whole table before accepting requests.

---
 rtl/frac_tcam_pkg.sv | 43 ++++
 rtl/frac_tcam_slice_enc.sv | 33 +++
 rtl/frac_tcam_wr.sv | 233 +++++++++++++++++++++++
 tb/tb_frac_tcam_wr.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_tcam_pkg.sv
// Shared definitions for the fractured TCAM rule-programming engine.
//
// Purpose: constants describing the SLICEM-based table geometry, the
//   writer FSM state encoding and the address-width helper used by every
//   file of the frac_tcam writer.
// Contents:
//   SLICE_WIDTH - key bits handled by one SRL column (5 -> 32 key values)
//   GROUP_SIZE  - entries that share one shift enable
//   GROUP_BITS  - log2(GROUP_SIZE)
//   SHIFT_LEN   - shift cycles needed to reload one group
//   CNT_WIDTH   - width of the shift counter
//   state_e     - writer FSM states
//   frac_tcam_clog2 - address width for a given depth (minimum 1)

package frac_tcam_pkg;

  localparam int SLICE_WIDTH = 5;
  localparam int GROUP_SIZE  = 8;
  localparam int GROUP_BITS  = 3;
  localparam int SHIFT_LEN   = 32;
  localparam int CNT_WIDTH   = 5;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  // Ceiling log2, clamped to at least one bit so a tiny table still has an
  // address port.
  function automatic int frac_tcam_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/frac_tcam_slice_enc.sv
// Per-slice match-bit encoder for one 8-entry group.
//
// Purpose: for the key value currently being shifted into the table, decide
//   for each of the eight entries whether that value matches the entry's
//   5-bit key slice under its don't-care mask. Purely combinational.
// Ports:
//   k_i     - key value being encoded (0..31)
//   key_i   - eight key slices, entry j at [j*5 +: 5]
//   mask_i  - eight mask slices, 1 = ignore that bit, entry j at [j*5 +: 5]
//   valid_i - eight entry valid bits
//   col_o   - one match bit per entry; invalid entries never match

module frac_tcam_slice_enc
  import frac_tcam_pkg::*;
(
  input  logic [SLICE_WIDTH-1:0]            k_i,
  input  logic [GROUP_SIZE*SLICE_WIDTH-1:0] key_i,
  input  logic [GROUP_SIZE*SLICE_WIDTH-1:0] mask_i,
  input  logic [GROUP_SIZE-1:0]             valid_i,
  output logic [GROUP_SIZE-1:0]             col_o
);

  // An entry matches when every bit that is not masked agrees with k.
  always_comb begin
    col_o = '0;
    for (int j = 0; j < GROUP_SIZE; j++) begin
      col_o[j] = valid_i[j] &&
                 (((k_i ^ key_i[j*SLICE_WIDTH +: SLICE_WIDTH]) &
                   ~mask_i[j*SLICE_WIDTH +: SLICE_WIDTH]) == '0);
    end
  end

endmodule

// File: rtl/frac_tcam_wr.sv
// Rule-programming engine (writer side) for the fractured TCAM table.
//
// Purpose: keeps a shadow copy of every entry (key, mask, valid) and, for
//   each install/delete request, rebuilds the affected 8-entry group by
//   shifting 32 columns of per-key-value match bits into the table. After
//   reset the whole table is first loaded with never-match data.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-low reset
//   wr_valid - request valid
//   wr_ready - engine can accept a request (IDLE only)
//   wr_addr  - entry index
//   wr_key   - rule key
//   wr_mask  - don't-care mask, 1 = ignore that bit
//   wr_set   - 1 = install/overwrite, 0 = delete
//   wr_done  - one-cycle pulse when a group rewrite completes
//   we       - per-group shift enable to the table
//   rules    - shift data, bit [s*8+j] = slice s, entry j of enabled group
// Optional (macro FRAC_TCAM_WR_READBACK_EN):
//   rd_addr  - shadow entry to read
//   rd_key, rd_mask, rd_valid - shadow entry contents, 1-cycle latency

module frac_tcam_wr
  import frac_tcam_pkg::*;
#(
  parameter  int TCAM_WIDTH = 5,
  parameter  int TCAM_DEPTH = 64,
  localparam int ADDR_WIDTH = frac_tcam_clog2(TCAM_DEPTH),
  localparam int NUM_SLICES = TCAM_WIDTH / SLICE_WIDTH,
  localparam int NUM_GROUPS = TCAM_DEPTH / GROUP_SIZE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [TCAM_WIDTH-1:0]             wr_key,
  input  logic [TCAM_WIDTH-1:0]             wr_mask,
  input  logic                              wr_set,
  output logic                              wr_done,
`ifdef FRAC_TCAM_WR_READBACK_EN
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [TCAM_WIDTH-1:0]             rd_key,
  output logic [TCAM_WIDTH-1:0]             rd_mask,
  output logic                              rd_valid,
`endif
  output logic [NUM_GROUPS-1:0]             we,
  output logic [NUM_SLICES*GROUP_SIZE-1:0]  rules
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(SHIFT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] K_FIRST   = CNT_WIDTH'(SHIFT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] K_AFTER1  = CNT_WIDTH'(SHIFT_LEN - 2);

  state_e                            state_q;
  logic [CNT_WIDTH-1:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]             gBase_q;
  logic [NUM_GROUPS-1:0]             we_q;
  logic [NUM_SLICES*GROUP_SIZE-1:0]  rules_q;
  logic                              wrReady_q;
  logic                              wrDone_q;

  logic [TCAM_WIDTH-1:0]             keyMem_q   [TCAM_DEPTH];
  logic [TCAM_WIDTH-1:0]             maskMem_q  [TCAM_DEPTH];
  logic [TCAM_DEPTH-1:0]             validMem_q;

  logic                              accept;
  logic [ADDR_WIDTH-1:0]             gBase_d;
  logic [SLICE_WIDTH-1:0]            k_d;
  logic [NUM_GROUPS-1:0]             we_d;
  logic [NUM_SLICES*GROUP_SIZE-1:0]  rules_d;

  logic [TCAM_WIDTH-1:0]             viewKey   [GROUP_SIZE];
  logic [TCAM_WIDTH-1:0]             viewMask  [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]             viewValid;

  logic [GROUP_SIZE*SLICE_WIDTH-1:0] sliceKey  [NUM_SLICES];
  logic [GROUP_SIZE*SLICE_WIDTH-1:0] sliceMask [NUM_SLICES];

  assign wr_ready = wrReady_q;
  assign wr_done  = wrDone_q;
  assign we       = we_q;
  assign rules    = rules_q;

  assign accept = (state_q == ST_IDLE) && wrReady_q && wr_valid;

  // The first column is computed in the accept cycle itself, so the group
  // and key value come straight from the request; afterwards they come from
  // the latched group and the running counter.
  assign gBase_d = accept ? (wr_addr & ~ADDR_WIDTH'(GROUP_SIZE - 1)) : gBase_q;
  assign k_d     = accept ? K_FIRST : (K_AFTER1 - cnt_q);

  // Group view: the entry being written this cycle is bypassed from the
  // request so the rebuild sees the new contents on its very first column.
  for (genvar j = 0; j < GROUP_SIZE; j++) begin : g_view
    logic [ADDR_WIDTH-1:0] idx;
    logic                  hit;
    assign idx          = gBase_d | ADDR_WIDTH'(j);
    assign hit          = accept && (wr_addr == idx);
    assign viewKey[j]   = hit ? wr_key  : keyMem_q[idx];
    assign viewMask[j]  = hit ? wr_mask : maskMem_q[idx];
    assign viewValid[j] = hit ? wr_set  : validMem_q[idx];
  end

  // One encoder per 5-bit slice, each fed that slice of all eight entries.
  for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
    for (genvar j = 0; j < GROUP_SIZE; j++) begin : g_pack
      assign sliceKey[s][j*SLICE_WIDTH +: SLICE_WIDTH] =
             viewKey[j][s*SLICE_WIDTH +: SLICE_WIDTH];
      assign sliceMask[s][j*SLICE_WIDTH +: SLICE_WIDTH] =
             viewMask[j][s*SLICE_WIDTH +: SLICE_WIDTH];
    end

    frac_tcam_slice_enc u_enc (
      .k_i     (k_d),
      .key_i   (sliceKey[s]),
      .mask_i  (sliceMask[s]),
      .valid_i (viewValid),
      .col_o   (rules_d[s*GROUP_SIZE +: GROUP_SIZE])
    );
  end

  // Shift enable for the selected group only; every other group holds.
  always_comb begin
    we_d = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      we_d[g] = ((gBase_d >> GROUP_BITS) == ADDR_WIDTH'(g));
    end
  end

  // Writer FSM. INIT shifts zeros into every group for 32 cycles, IDLE
  // waits for a request, LOAD shifts the 32 columns of the chosen group
  // (key value 31 first so it ends at the deepest SRL address).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      gBase_q   <= '0;
      we_q      <= '0;
      rules_q   <= '0;
      wrReady_q <= 1'b0;
      wrDone_q  <= 1'b0;
    end else begin
      wrDone_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          we_q    <= '1;
          rules_q <= '0;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          we_q      <= '0;
          rules_q   <= '0;
          wrReady_q <= 1'b1;
          if (accept) begin
            gBase_q   <= gBase_d;
            we_q      <= we_d;
            rules_q   <= rules_d;
            cnt_q     <= '0;
            wrReady_q <= 1'b0;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt_q == CNT_LAST) begin
            we_q      <= '0;
            rules_q   <= '0;
            wrDone_q  <= 1'b1;
            wrReady_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end else begin
            rules_q <= rules_d;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          we_q      <= '0;
          rules_q   <= '0;
          wrReady_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_INIT;
        end
      endcase
    end
  end

  // Shadow storage. Reset clears everything so a stale rule can never be
  // rebuilt into the table after INIT wiped it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      validMem_q <= '0;
      for (int i = 0; i < TCAM_DEPTH; i++) begin
        keyMem_q[i]  <= '0;
        maskMem_q[i] <= '0;
      end
    end else if (accept) begin
      keyMem_q[wr_addr]   <= wr_key;
      maskMem_q[wr_addr]  <= wr_mask;
      validMem_q[wr_addr] <= wr_set;
    end
  end

`ifdef FRAC_TCAM_WR_READBACK_EN
  logic [TCAM_WIDTH-1:0] rdKey_q;
  logic [TCAM_WIDTH-1:0] rdMask_q;
  logic                  rdValid_q;

  assign rd_key   = rdKey_q;
  assign rd_mask  = rdMask_q;
  assign rd_valid = rdValid_q;

  // Registered readback of the shadow; a write accepted this cycle shows up
  // on a read issued in a later cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdKey_q   <= '0;
      rdMask_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdKey_q   <= keyMem_q[rd_addr];
      rdMask_q  <= maskMem_q[rd_addr];
      rdValid_q <= validMem_q[rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_frac_tcam_wr.sv
// Testbench for frac_tcam_wr (default geometry: 5-bit keys, 64 entries).
// Keeps its own table of rules and derives every expected shift column by
// asking, bit by bit, whether a key value satisfies each ternary rule.
// Readback checks are included when FRAC_TCAM_WR_READBACK_EN is defined.

`timescale 1ns/1ps

module tb_frac_tcam_wr;

  localparam int W  = 5;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int NG = D / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_key;
  logic [W-1:0]  wr_mask;
  logic          wr_set;
  logic          wr_done;
  logic [NG-1:0] we;
  logic [7:0]    rules;
`ifdef FRAC_TCAM_WR_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_key;
  logic [W-1:0]  rd_mask;
  logic          rd_valid;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] mKey   [D];
  logic [W-1:0] mMask  [D];
  logic         mValid [D];

  always #5 clk = ~clk;

  frac_tcam_wr #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_key   (wr_key),
    .wr_mask  (wr_mask),
    .wr_set   (wr_set),
    .wr_done  (wr_done),
`ifdef FRAC_TCAM_WR_READBACK_EN
    .rd_addr  (rd_addr),
    .rd_key   (rd_key),
    .rd_mask  (rd_mask),
    .rd_valid (rd_valid),
`endif
    .we       (we),
    .rules    (rules)
  );

  // Does key value k satisfy the rule stored in model entry e?
  function automatic logic ruleHits(int e, int k);
    logic ok;
    ok = mValid[e];
    for (int b = 0; b < W; b++) begin
      if (!mMask[e][b] && (((k >> b) & 1) != int'(mKey[e][b]))) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [7:0] expCol(int g, int k);
    logic [7:0] c;
    c = '0;
    for (int j = 0; j < 8; j++) c[j] = ruleHits(g * 8 + j, k);
    return c;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < D; i++) begin
      mKey[i] = '0; mMask[i] = '0; mValid[i] = 1'b0;
    end
  endtask

  // Expect 32 cycles of all-group enables with zero data, then IDLE.
  task automatic checkInit();
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (we !== 8'hFF || rules !== 8'h00 || wr_ready !== 1'b0 || wr_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL init cycle %0d: we=%h rules=%h ready=%b done=%b, expected we=ff rules=00 ready=0 done=0",
                 i, we, rules, wr_ready, wr_done);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (we !== 8'h00 || wr_ready !== 1'b1 || wr_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL init_exit: we=%h ready=%b done=%b, expected we=00 ready=1 done=0",
               we, wr_ready, wr_done);
    end
  endtask

  // Wait (bounded) for wr_ready, present the request and let it be taken.
  task automatic acceptRequest(input int addr, input int key, input int mask, input logic set);
    int waited = 0;
    while (wr_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: wr_ready=%b after %0d cycles, expected 1", wr_ready, waited);
    end
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_key   = W'(key);
    wr_mask  = W'(mask);
    wr_set   = set;
    @(posedge clk); #1;
    mKey[addr]   = W'(key);
    mMask[addr]  = W'(mask);
    mValid[addr] = set;
    wr_valid     = 1'b0;
  endtask

  // Check the 32-column rebuild of group g and the completion cycle.
  // hits collects the stream of entry j's bit, indexed by column number.
  task automatic checkRebuild(input int g, input int j, output logic [31:0] hits);
    logic [7:0] one;
    logic [7:0] expWe;
    logic [7:0] expRules;
    one   = 8'h01;
    expWe = one << g;
    hits  = '0;
    for (int c = 0; c < 32; c++) begin
      expRules = expCol(g, 31 - c);
      vectors++;
      if (we !== expWe || rules !== expRules || wr_ready !== 1'b0 || wr_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rebuild g=%0d c=%0d: we=%h rules=%h ready=%b done=%b, expected we=%h rules=%h ready=0 done=0",
                 g, c, we, rules, wr_ready, wr_done, expWe, expRules);
      end
      hits[c] = rules[j];
      @(posedge clk); #1;
    end
    vectors++;
    if (we !== 8'h00 || wr_done !== 1'b1 || wr_ready !== 1'b1 || rules !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rebuild_done g=%0d: we=%h rules=%h done=%b ready=%b, expected we=00 rules=00 done=1 ready=1",
               g, we, rules, wr_done, wr_ready);
    end
  endtask

  task automatic checkHits(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: stream=%h, expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_key   = '0;
    wr_mask  = '0;
    wr_set   = 1'b0;
`ifdef FRAC_TCAM_WR_READBACK_EN
    rd_addr  = '0;
`endif
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (we !== 8'h00 || rules !== 8'h00 || wr_ready !== 1'b0 || wr_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: we=%h rules=%h ready=%b done=%b, expected all 0",
               we, rules, wr_ready, wr_done);
    end
    reset = 1'b1;
    checkInit();
  endtask

  task automatic test_install_exact();
    logic [31:0] hits;
    acceptRequest(3, 5'h0A, 5'h00, 1'b1);
    checkRebuild(0, 3, hits);
    checkHits("install_a3_k0a", hits, 32'h1 << 21);
  endtask

  task automatic test_mask_and_delete();
    logic [31:0] hits;
    acceptRequest(12, 5'h10, 5'h0F, 1'b1);
    checkRebuild(1, 4, hits);
    checkHits("install_a12_masked", hits, 32'h0000FFFF);
    acceptRequest(12, 5'h10, 5'h0F, 1'b0);
    checkRebuild(1, 4, hits);
    checkHits("delete_a12", hits, 32'h0);
    acceptRequest(12, 5'h05, 5'h00, 1'b0);
    checkRebuild(1, 4, hits);
    checkHits("delete_invalid_a12", hits, 32'h0);
    acceptRequest(40, 5'h13, 5'h1F, 1'b1);
    checkRebuild(5, 0, hits);
    checkHits("match_all_a40", hits, 32'hFFFFFFFF);
  endtask

  task automatic test_same_group();
    logic [31:0] hits;
    logic [31:0] hits8;
    acceptRequest(8, 5'h01, 5'h00, 1'b1);
    checkRebuild(1, 0, hits);
    acceptRequest(9, 5'h01, 5'h00, 1'b1);
    checkRebuild(1, 1, hits);
    checkHits("same_group_a9", hits, 32'h1 << 30);
    acceptRequest(10, 5'h02, 5'h00, 1'b1);
    checkRebuild(1, 0, hits8);
    checkHits("same_group_a8_kept", hits8, 32'h1 << 30);
  endtask

  task automatic test_back_to_back();
    logic [31:0] hits;
    acceptRequest(16, 5'h03, 5'h00, 1'b1);
    wr_valid = 1'b1;
    wr_addr  = AW'(17);
    wr_key   = 5'h03;
    wr_mask  = 5'h00;
    wr_set   = 1'b1;
    checkRebuild(2, 1, hits);
    checkHits("b2b_not_early", hits, 32'h0);
    acceptRequest(17, 5'h03, 5'h00, 1'b1);
    checkRebuild(2, 1, hits);
    checkHits("b2b_second", hits, 32'h1 << 28);
  endtask

  task automatic test_random();
    logic [31:0] hits;
    int addr;
    int key;
    int mask;
    int sel;
    logic set;
    for (int n = 0; n < 20; n++) begin
      addr = $urandom_range(0, D - 1);
      key  = $urandom_range(0, 31);
      sel  = $urandom_range(0, 3);
      mask = (sel == 0) ? 0 : (sel == 1) ? 31 : $urandom_range(0, 31);
      set  = ($urandom_range(0, 3) != 0);
      acceptRequest(addr, key, mask, set);
      checkRebuild(addr / 8, addr % 8, hits);
`ifdef FRAC_TCAM_WR_READBACK_EN
      rd_addr = AW'($urandom_range(0, D - 1));
      if (n % 2 == 0) rd_addr = AW'(addr);
`endif
      @(posedge clk); #1;
      vectors++;
      if (we !== 8'h00 || rules !== 8'h00 || wr_done !== 1'b0 || wr_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL idle_after_%0d: we=%h rules=%h done=%b ready=%b, expected we=00 rules=00 done=0 ready=1",
                 n, we, rules, wr_done, wr_ready);
      end
`ifdef FRAC_TCAM_WR_READBACK_EN
      vectors++;
      if (rd_key !== mKey[rd_addr] || rd_mask !== mMask[rd_addr] || rd_valid !== mValid[rd_addr]) begin
        miscompares++;
        $display("[TB] FAIL readback a=%0d: key=%h mask=%h valid=%b, expected key=%h mask=%h valid=%b",
                 rd_addr, rd_key, rd_mask, rd_valid, mKey[rd_addr], mMask[rd_addr], mValid[rd_addr]);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] hits;
    acceptRequest(50, 5'h07, 5'h00, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (we !== 8'h00 || rules !== 8'h00 || wr_ready !== 1'b0 || wr_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_load: we=%h rules=%h ready=%b done=%b, expected all 0",
               we, rules, wr_ready, wr_done);
    end
    clearModel();
    reset = 1'b1;
    checkInit();
`ifdef FRAC_TCAM_WR_READBACK_EN
    rd_addr = AW'(50);
    @(posedge clk); #1;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL readback_after_reset: rd_valid=%b, expected 0", rd_valid);
    end
`endif
    acceptRequest(51, 5'h07, 5'h00, 1'b1);
    checkRebuild(6, 2, hits);
    checkHits("after_reset_a50_gone", hits, 32'h0);
  endtask

  initial begin
    $display("[TB] starting frac_tcam_wr checks");
    test_reset();
    test_install_exact();
    test_mask_and_delete();
    test_same_group();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
